// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC register, the IF/ID pipeline register
// and saturating counters of decode stall and flush events.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  assign pc_plus4 = PCF + 32'd4;
  assign pc_next  = PCSrcE ? PCTargetE : pc_plus4;

  // A redirect from Execute belongs to an older instruction, so it overrides a fetch stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= 32'h0000_0000;
    end else if (PCSrcE || !StallF) begin
      PCF <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD   <= NopInstr;
      PCD      <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NopInstr;
      PCD      <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4;
      ValidD   <= 1'b1;
    end
  end

  // A flush masks a simultaneous stall, so only flush is counted in that case.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= 16'h0000;
      FlushCnt <= 16'h0000;
    end else begin
      if (FlushD) begin
        if (FlushCnt != 16'hFFFF) FlushCnt <= FlushCnt + 16'd1;
      end else if (StallD) begin
        if (StallCnt != 16'hFFFF) StallCnt <= StallCnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the fetch rules.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic [31:0] instr_f = '0;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic [31:0] m_pcp4;
  logic        m_valid;
  int          m_scnt;
  int          m_fcnt;

  if_stage dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (stall_f),
    .StallD    (stall_d),
    .FlushD    (flush_d),
    .PCSrcE    (pc_src_e),
    .PCTargetE (pc_target_e),
    .InstrF    (instr_f),
    .PCF       (pc_f),
    .InstrD    (instr_d),
    .PCD       (pc_d),
    .PCPlus4D  (pc_plus4_d),
    .ValidD    (valid_d),
    .StallCnt  (stall_cnt),
    .FlushCnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [160:0] dut_vec();
    return {pc_f, instr_d, pc_d, pc_plus4_d, valid_d, stall_cnt, flush_cnt};
  endfunction

  function automatic logic [160:0] model_vec();
    return {m_pc, m_instr, m_pcd, m_pcp4, m_valid, m_scnt[15:0], m_fcnt[15:0]};
  endfunction

  // Advance the model by one edge from the rules, then apply the same inputs to the DUT.
  task automatic cycle(input logic rst, input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] tgt, input logic [31:0] instr);
    logic [31:0] next_pc;
    reset = rst; stall_f = sf; stall_d = sd; flush_d = fd;
    pc_src_e = ps; pc_target_e = tgt; instr_f = instr;
    if (rst) begin
      next_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
      m_scnt = 0; m_fcnt = 0;
    end else begin
      if (ps) next_pc = tgt;
      else if (sf) next_pc = m_pc;
      else next_pc = m_pc + 32'd4;
      if (fd) begin
        m_instr = 32'h13; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
        if (m_fcnt < 65535) m_fcnt = m_fcnt + 1;
      end else if (sd) begin
        if (m_scnt < 65535) m_scnt = m_scnt + 1;
      end else begin
        m_instr = instr; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1;
      end
    end
    m_pc = next_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 1, 1, 32'h1234_5678, 32'hDEAD_BEEF);
    checks++;
    if (dut_vec() !== {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset_values actual=%h required=%h", dut_vec(),
               {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0});
    end
  endtask

  task automatic test_sequential();
    logic [31:0] seq [3];
    seq[0] = 32'hAAAA_0001; seq[1] = 32'hAAAA_0002; seq[2] = 32'hAAAA_0003;
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0, seq[i]);
      checks++;
      if ({pc_f, instr_d, pc_d, pc_plus4_d, valid_d} !==
          {32'(4 * (i + 1)), seq[i], 32'(4 * i), 32'(4 * i + 4), 1'b1}) begin
        failures++;
        $display("FAIL sequential_%0d actual pc=%h instr=%h pcd=%h pcp4=%h v=%b required pc=%h instr=%h pcd=%h",
                 i, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, 4 * (i + 1), seq[i], 4 * i);
      end
    end
  endtask

  task automatic test_load_use();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 32'hAAAA_0001);
    cycle(0, 0, 0, 0, 0, 0, 32'hAAAA_0002);
    for (int i = 0; i < 2; i++) cycle(0, 1, 1, 0, 0, 0, 32'hBBBB_0000 + 32'(i));
    checks++;
    if ({pc_f, instr_d, pc_d, stall_cnt} !== {32'h8, 32'hAAAA_0002, 32'h4, 16'd2}) begin
      failures++;
      $display("FAIL load_use_hold actual pc=%h instr=%h pcd=%h scnt=%0d required pc=8 instr=aaaa0002 pcd=4 scnt=2",
               pc_f, instr_d, pc_d, stall_cnt);
    end
    cycle(0, 0, 0, 0, 0, 0, 32'hAAAA_0003);
    checks++;
    if ({pc_f, instr_d, pc_d, valid_d} !== {32'hC, 32'hAAAA_0003, 32'h8, 1'b1}) begin
      failures++;
      $display("FAIL load_use_resume actual pc=%h instr=%h pcd=%h v=%b required pc=c instr=aaaa0003 pcd=8 v=1",
               pc_f, instr_d, pc_d, valid_d);
    end
  endtask

  task automatic test_branch();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 32'h1111_1111);
    cycle(0, 0, 0, 1, 1, 32'h100, 32'h2222_2222);
    checks++;
    if ({pc_f, instr_d, valid_d, flush_cnt} !== {32'h100, 32'h13, 1'b0, 16'd1}) begin
      failures++;
      $display("FAIL branch_redirect actual pc=%h instr=%h v=%b fcnt=%0d required pc=100 instr=13 v=0 fcnt=1",
               pc_f, instr_d, valid_d, flush_cnt);
    end
  endtask

  task automatic test_redirect_during_stall();
    logic [15:0] s0, f0;
    cycle(0, 1, 1, 0, 0, 0, 32'h3333_3333);
    s0 = stall_cnt; f0 = flush_cnt;
    cycle(0, 1, 1, 1, 1, 32'h40, 32'h4444_4444);
    checks++;
    if ({pc_f, instr_d, pc_d, pc_plus4_d, valid_d, stall_cnt, flush_cnt} !==
        {32'h40, 32'h13, 32'h0, 32'h0, 1'b0, s0, f0 + 16'd1}) begin
      failures++;
      $display("FAIL redirect_stall actual pc=%h instr=%h v=%b scnt=%0d fcnt=%0d required pc=40 instr=13 v=0 scnt=%0d fcnt=%0d",
               pc_f, instr_d, valid_d, stall_cnt, flush_cnt, s0, f0 + 16'd1);
    end
  endtask

  task automatic test_wrap_reset();
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h5555_5555);
    cycle(0, 0, 0, 0, 0, 0, 32'h6666_6666);
    checks++;
    if ({pc_f, pc_d, pc_plus4_d} !== {32'h0, 32'hFFFF_FFFC, 32'h0}) begin
      failures++;
      $display("FAIL pc_wrap actual pc=%h pcd=%h pcp4=%h required pc=0 pcd=fffffffc pcp4=0",
               pc_f, pc_d, pc_plus4_d);
    end
    cycle(0, 1, 1, 0, 0, 0, 32'h7777_7777);
    cycle(1, 1, 1, 0, 0, 0, 32'h8888_8888);
    checks++;
    if (dut_vec() !== {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset_mid_stall actual=%h required=%h", dut_vec(),
               {32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0});
    end
    cycle(0, 0, 0, 0, 0, 0, 32'h9999_9999);
    checks++;
    if ({pc_f, instr_d, pc_d, valid_d} !== {32'h4, 32'h9999_9999, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL restart_fetch actual pc=%h instr=%h pcd=%h v=%b required pc=4 instr=99999999 pcd=0 v=1",
               pc_f, instr_d, pc_d, valid_d);
    end
  endtask

  task automatic test_random();
    logic rst, sf, sd, fd, ps;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      fd  = ($urandom_range(0, 5) == 0);
      ps  = ($urandom_range(0, 5) == 0);
      cycle(rst, sf, sd, fd, ps, {$urandom} & 32'hFFFF_FFFC, $urandom);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL random_%0d actual=%h required=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_saturation();
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) cycle(0, 1, 1, 0, 0, 0, 32'h0);
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      failures++;
      $display("FAIL stall_cnt_pre_sat actual=%h required=fffe", stall_cnt);
    end
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0, 0, 32'h0);
    checks++;
    if (dut_vec() !== model_vec() || stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_cnt_saturate actual=%h required=%h", dut_vec(), model_vec());
    end
    cycle(0, 1, 1, 1, 0, 0, 32'h0);
    checks++;
    if ({stall_cnt, flush_cnt} !== {16'hFFFF, 16'd1}) begin
      failures++;
      $display("FAIL flush_over_stall_count actual scnt=%h fcnt=%h required scnt=ffff fcnt=1",
               stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    m_pc = 0; m_instr = 32'h13; m_pcd = 0; m_pcp4 = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
    #1;
    test_reset();
    test_sequential();
    test_load_use();
    test_branch();
    test_redirect_during_stall();
    test_wrap_reset();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
